// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state type for the round-robin decoded arbiter
package arb_pkg;

    localparam int N_REQ  = 16;
    localparam int IDX_W  = 4;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dec4to16.sv
// rtl/dec4to16.sv - 4-to-16 one-hot decoder
module dec4to16 (
    input  logic [3:0]  sel,
    output logic [15:0] dec
);

    // one-hot decode of the select index
    always_comb begin
        dec = 16'd1 << sel;
    end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority finder: first set request at or above base, wrapping
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] base,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // scan from the far end back toward base so the last hit is the closest to base
    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = base + IDX_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_dec_arbiter.sv
// rtl/rr_dec_arbiter.sv - 16-way round-robin arbiter with decoded grant; optional ARB_TIMEOUT_EN hold limit
module rr_dec_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0] ptr,
    output logic             timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD out of range 1..255");
    end

    arb_state_t       state, state_next;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             force_rel;
    logic             tmo_next;
    logic             rel;
    logic [N_REQ-1:0] dec_out;

    rr_pick u_pick (
        .req  (req),
        .base (ptr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_hit;

    // hold_cnt == MAX_HOLD-1 in the last permitted GRANT cycle; the release edge is the MAX_HOLD-th
    always_comb begin
        hold_hit  = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
        force_rel = hold_hit;
        tmo_next  = hold_hit && !done;
    end

    // hold counter: cleared while idle (so it starts at 0 on grant), counts GRANT cycles
    always_ff @(posedge clk) begin
        if (rst || state != GRANT) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    // no hold limit: a grant lasts until done or withdrawal
    always_comb begin
        force_rel = 1'b0;
        tmo_next  = 1'b0;
    end
`endif

    // next-state: grant on any request in IDLE, release on done/withdrawal/hold limit
    always_comb begin
        state_next = state;
        rel        = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                rel = done || !req[gnt_idx] || force_rel;
                if (rel) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // state, owner, priority base and timeout pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            gnt_valid <= (state_next == GRANT);
            timeout   <= rel && tmo_next;
            if (state == IDLE && pick_any) begin
                gnt_idx <= pick_idx;
            end
            if (rel) begin
                ptr <= gnt_idx + 1'b1;
            end
        end
    end

    dec4to16 u_dec (
        .sel (gnt_idx),
        .dec (dec_out)
    );

    // decoded select only while a grant is active
    always_comb begin
        gnt_oh = dec_out & {N_REQ{gnt_valid}};
    end

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// tb/tb_rr_dec_arbiter.sv - directed scoreboard bench for rr_dec_arbiter
module tb_rr_dec_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic        gnt_valid;
    logic [3:0]  gnt_idx;
    logic [15:0] gnt_oh;
    logic [3:0]  ptr;
    logic        timeout;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       v;
        logic [3:0] i;
        logic [3:0] p;
        logic       t;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rr_dec_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_oh    (gnt_oh),
        .ptr       (ptr),
        .timeout   (timeout)
    );

    task automatic step(input logic r_rst, input logic [15:0] r_req, input logic r_done,
                        input logic ev, input logic [3:0] ei, input logic [3:0] ep,
                        input logic et, input string tag);
        exp_t e;
        logic [15:0] eoh;
        e.v = ev; e.i = ei; e.p = ep; e.t = et; e.tag = tag;
        sb.push_back(e);
        rst  = r_rst;
        req  = r_req;
        done = r_done;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        eoh = e.v ? (16'd1 << e.i) : 16'd0;
        vectors++;
        assert (gnt_valid === e.v) else begin
            miscompares++;
            $error("FAIL %s gnt_valid observed=%b expected=%b", e.tag, gnt_valid, e.v);
        end
        vectors++;
        assert (gnt_idx === e.i) else begin
            miscompares++;
            $error("FAIL %s gnt_idx observed=%0d expected=%0d", e.tag, gnt_idx, e.i);
        end
        vectors++;
        assert (gnt_oh === eoh) else begin
            miscompares++;
            $error("FAIL %s gnt_oh observed=%h expected=%h", e.tag, gnt_oh, eoh);
        end
        vectors++;
        assert (ptr === e.p) else begin
            miscompares++;
            $error("FAIL %s ptr observed=%0d expected=%0d", e.tag, ptr, e.p);
        end
        vectors++;
        assert (timeout === e.t) else begin
            miscompares++;
            $error("FAIL %s timeout observed=%b expected=%b", e.tag, timeout, e.t);
        end
    endtask

    initial begin
        rst = 1'b1; req = 16'hFFFF; done = 1'b0;

        // reset with everyone requesting
        step(1, 16'hFFFF, 0, 0, 0, 0, 0, "reset0");
        step(1, 16'hFFFF, 0, 0, 0, 0, 0, "reset1");
        step(0, 16'hFFFF, 0, 1, 0, 0, 0, "first_grant");
        step(0, 16'hFFFF, 1, 0, 0, 1, 0, "first_release");

        // single requester
        step(0, 16'h0020, 0, 1, 5, 1, 0, "single_grant");
        step(0, 16'h0020, 0, 1, 5, 1, 0, "single_hold");
        step(0, 16'h0020, 1, 0, 5, 6, 0, "single_release");

        // wrap-around through ptr=15
        step(0, 16'h4000, 0, 1, 14, 6, 0, "to14_grant");
        step(0, 16'h4000, 1, 0, 14, 15, 0, "to14_release");
        step(0, 16'h8001, 0, 1, 15, 15, 0, "wrap_grant15");
        step(0, 16'h8001, 1, 0, 15, 0, 0, "wrap_release15");
        step(0, 16'h8001, 0, 1, 0, 0, 0, "wrap_grant0");
        step(0, 16'h8001, 1, 0, 0, 1, 0, "wrap_release0");
        step(0, 16'h0000, 1, 0, 0, 1, 0, "idle_done_ignored");

        // fairness: all requesting, done every grant, one gap cycle each
        step(1, 16'hFFFF, 0, 0, 0, 0, 0, "fair_reset");
        for (int k = 0; k <= 16; k++) begin
            step(0, 16'hFFFF, 0, 1, 4'(k), 4'(k), 0, "fair_grant");
            step(0, 16'hFFFF, 1, 0, 4'(k), 4'(k + 1), 0, "fair_gap");
        end

        // withdrawal, other-bit changes, mid-grant reset
        step(0, 16'h0008, 0, 1, 3, 1, 0, "wd_grant");
        step(0, 16'h0000, 0, 0, 3, 4, 0, "wd_release");
        step(0, 16'h0008, 0, 1, 3, 4, 0, "wd_regrant");
        step(0, 16'hFFF8, 0, 1, 3, 4, 0, "wd_other_bits");
        step(1, 16'h0008, 0, 0, 0, 0, 0, "mid_grant_reset");
        step(0, 16'h0000, 0, 0, 0, 0, 0, "post_reset_idle");

`ifdef ARB_TIMEOUT_EN
        // forced revocation after 4 GRANT cycles
        step(0, 16'h0004, 0, 1, 2, 0, 0, "to_grant");
        step(0, 16'h0004, 0, 1, 2, 0, 0, "to_hold2");
        step(0, 16'h0004, 0, 1, 2, 0, 0, "to_hold3");
        step(0, 16'h0004, 0, 1, 2, 0, 0, "to_hold4");
        step(0, 16'h0004, 0, 0, 2, 3, 1, "to_revoke");
        step(0, 16'h0000, 0, 0, 2, 3, 0, "to_pulse_end");
        // done coinciding with the limit is a normal release
        step(0, 16'h0004, 0, 1, 2, 3, 0, "tod_grant");
        step(0, 16'h0004, 0, 1, 2, 3, 0, "tod_hold2");
        step(0, 16'h0004, 0, 1, 2, 3, 0, "tod_hold3");
        step(0, 16'h0004, 0, 1, 2, 3, 0, "tod_hold4");
        step(0, 16'h0004, 1, 0, 2, 3, 0, "tod_release");
`else
        // without the hold limit a grant persists well past MAX_HOLD
        step(0, 16'h0004, 0, 1, 2, 0, 0, "nto_grant");
        for (int k = 0; k < 8; k++) begin
            step(0, 16'h0004, 0, 1, 2, 0, 0, "nto_hold");
        end
        step(0, 16'h0004, 1, 0, 2, 3, 0, "nto_release");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_dec_arbiter.md
Name: rr_dec_arbiter

Overview:
- Round-robin arbiter that shares one 16-way resource among 16 requesters.
- The resource is a 16-entry register/bank select driven through a 4-to-16 decoder.
- Produces a registered 4-bit grant index and its one-hot decode.
- Holds each grant until the owner releases it; rotates priority after each release.

Parameters:
- MAX_HOLD, 15, maximum cycles a grant may be held before forced revocation. Used only when ARB_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  16  request vector; bit i = requester i wants the resource.
- done  input  1  release strobe from the current owner; sampled only in GRANT.
- gnt_valid  output  1  a grant is active.
- gnt_idx  output  4  index of the current owner; registered.
- gnt_oh  output  16  one-hot decode of gnt_idx, gated by gnt_valid (all-zero when gnt_valid=0).
- ptr  output  4  current rotating-priority base, for debug/observation.
- timeout  output  1  one-cycle pulse on forced revocation; tied 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset is synchronous, active-high, and applied on the clk edge while rst=1. Reset values:
  - state=IDLE
  - ptr=0
  - gnt_valid=0
  - gnt_idx=0
  - gnt_oh=0
  - timeout=0
  - hold counter=0
- Reset mid-grant drops the grant at that edge. No release handshake is performed.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0: pick the first set bit scanning from ptr upward, wrapping 15->0 (mod 16).
  - At the next edge: gnt_idx=pick, gnt_valid=1, state=GRANT.
  - If req == 0: remain in IDLE.
- Latency: request seen at edge t is granted visibly after edge t+1 (one cycle).
- GRANT: release occurs when done=1, or when req[gnt_idx]=0 (requester withdrew). On release, at the next edge:
  - gnt_valid=0, state=IDLE
  - ptr=(gnt_idx+1) mod 16 (15 wraps to 0)
  - gnt_idx retains its last value
- Guaranteed gap: one IDLE cycle with gnt_valid=0 always separates consecutive grants, including back-to-back grants to the same requester.
- done asserted in IDLE is ignored.
- Changes to req bits other than gnt_idx during GRANT have no effect.
- ptr changes only on release or revocation, never on grant.
- gnt_oh is combinational from the registered gnt_idx/gnt_valid, so it is glitch-free relative to clk.
- Fairness: with all 16 requesting continuously, each is granted exactly once per 16 grants.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD with no release, the next edge forces release (same as a done release, ptr advances) and pulses timeout=1 for one cycle.
  - If done and timeout coincide, it is treated as a normal release and timeout stays 0.
- Undefined: no counter is present, timeout is tied 0, and a grant is held indefinitely.

Decomposition:
- Shared package arb_pkg holds:
  - N_REQ=16, IDX_W=4
  - the state enum {IDLE, GRANT}
  - HOLD_W=8
- One natural sub-module: rr_pick.
  - Combinational rotating-priority finder: inputs req[15:0] and base[3:0]; outputs idx[3:0] and any.
- gnt_oh reuses the team's existing 4-to-16 decoder instance, with its output ANDed with gnt_valid.

Test Plan:
- Reset: assert rst for 2 cycles with req=16'hFFFF -> gnt_valid=0, gnt_oh=0, ptr=0 throughout. First grant after release of rst is idx 0.
- Single requester: req=16'h0020 -> gnt_idx=5 and gnt_oh=16'h0020 one cycle later. Pulse done -> gnt_valid=0 next cycle, ptr=6.
- Wrap-around: ptr=15 with req=16'h8001 -> grant idx 15. After done, ptr=0 and the next grant is idx 0. After that done, ptr=1.
- Fairness: req=16'hFFFF held and done pulsed every grant -> grant sequence 0,1,...,15,0, each grant separated by exactly one gnt_valid=0 cycle.
- Withdrawal/mid-grant reset: grant idx 3, drop req[3] -> release and ptr=4. Re-grant, then assert rst during GRANT -> gnt_valid=0 and ptr=0 at that edge.
- With ARB_TIMEOUT_EN and MAX_HOLD=4: grant idx 2 with done held 0 -> timeout pulses once and gnt_valid falls after 4 GRANT cycles, ptr=3. With done on the 4th cycle -> timeout=0.
